ahb_load_align_pipe: RTL
========================

// Module: ahb_load_align_pipe
// PURPOSE
// Registered load-data formatter for the AHB slave read path. Accepts raw HRDATA with
// the transfer's low address bits, HSIZE and signedness; extracts the addressed byte
// lane(s), zero/sign-extends to DATA_W and flags misaligned or oversize accesses.
// Valid/ready pipelined with a 2-entry skid buffer: full throughput, registered in_ready.
// Sits between the AHB slave read mux and the core's writeback stage.
// PARAMETERS
// DATA_W   32  data path width; legal values 32 or 64
// OFF_W    $clog2(DATA_W/8)  byte-offset width (derived, do not override)
// PORTS
// clk        in   1       core clock
// rst        in   1       synchronous, active-high reset
// in_valid   in   1       request beat valid
// in_ready   out  1       block can accept a beat (registered)
// in_addr    in   OFF_W   HADDR low bits of the transfer
// in_hsize   in   3       HSIZE: 000 byte, 001 half, 010 word, 011 dword
// in_signed  in   1       1 = sign-extend, 0 = zero-extend
// in_hrdata  in   DATA_W  raw read data, lane-aligned as on the bus
// out_valid  out  1       result valid
// out_ready  in   1       consumer accepts result
// out_data   out  DATA_W  aligned, extended load value
// out_err    out  1       misaligned or unsupported size (qualified by out_valid)
// BEHAVIOUR
// - Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_err=0, in_ready=1, skid empty.
// - Reset mid-stream drops all held beats; no partial result is emitted afterwards.
// - Transfer on in_valid&in_ready; result on out_valid&out_ready. Latency 1 cycle when
//   the output is free; 1 beat/cycle sustained with out_ready held high.
// - Extraction: sh = in_hrdata >> (in_addr*8); keep low 2^hsize bytes; MSB of kept field
//   replicated if in_signed, else zeros. Computed combinationally before the output
//   register; in_addr bits above the size granularity are used, bits below must be 0.
// - Misaligned: in_addr mod 2^hsize != 0 -> out_err=1, out_data=0.
// - Oversize: 2^hsize > DATA_W/8 or hsize >= 3'b100 -> out_err=1, out_data=0.
// - dword (011) with DATA_W=64: full 64-bit pass-through, in_signed ignored.
// - Skid: main output reg + one skid reg. When out_valid & !out_ready and a beat arrives,
//   it goes to skid; in_ready deasserts the following cycle. Order strictly FIFO.
// - in_ready = !skid_full (registered). A beat accepted while skid empties is legal.
// - Simultaneous out accept and in accept with skid empty: output reg reloads directly.
// - When the skid drains to output, in_ready returns to 1 on the next cycle.
// - out_data/out_err stable while out_valid & !out_ready (AXI-style hold).
// - in_* fields are don't-care when in_valid=0; no X propagates to out_* on idle cycles.
// STRUCTURE
// - Package ahb_load_pkg: hsize_e enum (HSZ_BYTE..HSZ_DWORD), function
//   load_extract(data, off, hsize, signed) returning {err, value}; shared with the
//   store-side lane steering block.
// - Sub-module load_skid_buf #(W): generic 2-entry valid/ready skid buffer carrying
//   {err, data}; this block = load_extract + load_skid_buf.
// TESTING
// - Reset: hold rst 3 cycles mid-traffic -> out_valid=0, in_ready=1 on the cycle after.
// - DATA_W=32, hrdata=32'h80F1_7F02, addr=2, byte, signed -> out_data=32'hFFFF_FFF1, err=0.
// - Same data, addr=2, half, unsigned -> 32'h0000_80F1; addr=1, half -> err=1, data=0.
// - DATA_W=64, hrdata=64'h8000_0001_0000_0000, addr=4, word, signed -> 64'hFFFF_FFFF_8000_0001;
//   dword on DATA_W=32 -> err=1.
// - Backpressure: stream 4 beats, out_ready=0 cycles 2-4 -> in_ready drops after 2nd held
//   beat, all 4 emitted in order, none lost/duplicated.
// - Throughput: 16 back-to-back beats, out_ready=1 -> 16 results on 16 consecutive cycles.

Source files
------------

// File: rtl/ahb_load_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_load_pkg
//  Description : Shared types and the load-lane extraction function used by
//                the AHB read-path formatter and the store-side lane steering.
//  Revision    : 1.0  initial release
// ============================================================================
package ahb_load_pkg;

    // AHB HSIZE encodings relevant to a 32/64-bit data path
    typedef enum logic [2:0] {
        HSZ_BYTE  = 3'b000,
        HSZ_HALF  = 3'b001,
        HSZ_WORD  = 3'b010,
        HSZ_DWORD = 3'b011
    } hsize_e;

    // Packed as {err, value}; value is always computed at the widest bus width
    typedef struct packed {
        logic        err;
        logic [63:0] value;
    } load_res_t;

    // Extract the addressed lane(s) of a read beat and extend to 64 bits.
    // bus_bytes is the physical bus width in bytes (4 or 8); any access wider
    // than the bus, or an HSIZE beyond dword, is reported as an error.
    function automatic load_res_t load_extract(
        input logic [63:0] data,
        input logic [2:0]  off,
        input logic [2:0]  hsize,
        input logic        sgn,
        input logic [3:0]  bus_bytes
    );
        load_res_t   res;
        logic [63:0] sh;
        logic [3:0]  nbytes;
        logic        misal;
        logic        over;

        sh     = data >> {off, 3'b000};
        nbytes = 4'd1 << hsize[1:0];
        over   = hsize[2] || (nbytes > bus_bytes);

        case (hsize)
            HSZ_BYTE: misal = 1'b0;
            HSZ_HALF: misal = off[0];
            HSZ_WORD: misal = |off[1:0];
            default:  misal = |off;
        endcase

        res.err   = misal | over;
        res.value = '0;
        if (!res.err) begin
            case (hsize)
                HSZ_BYTE: res.value = {{56{sgn & sh[7]}},  sh[7:0]};
                HSZ_HALF: res.value = {{48{sgn & sh[15]}}, sh[15:0]};
                HSZ_WORD: res.value = {{32{sgn & sh[31]}}, sh[31:0]};
                // Full-width dword: extension is meaningless, pass through
                default:  res.value = sh;
            endcase
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : load_skid_buf
//  Description : Generic 2-entry valid/ready skid buffer. Main output register
//                plus one skid register; in_ready is a registered flag that is
//                low exactly while the skid register holds a beat.
//  Revision    : 1.0  initial release
// ============================================================================
module load_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;
    logic         r_in_ready;
    logic         w_in_fire;

    assign w_in_fire = in_valid & r_in_ready;

    // Output/skid registers: output reloads whenever it is empty or being
    // consumed; a beat arriving while the output stalls parks in the skid.
    // The skid can only be full when in_ready is low, so it never receives
    // a new beat in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_in_fire) begin
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_data  <= in_data;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: rtl/ahb_load_align_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_load_align_pipe
//  Description : Registered AHB load-data formatter. Extracts the addressed
//                byte lane(s) from HRDATA, zero/sign-extends to DATA_W, flags
//                misaligned or oversize accesses, and hands the result on
//                through a 2-entry skid buffer at full throughput.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_load_align_pipe
    import ahb_load_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OFF_W-1:0]  in_addr,
    input  logic [2:0]        in_hsize,
    input  logic              in_signed,
    input  logic [DATA_W-1:0] in_hrdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam int         c_PKT_W     = DATA_W + 1;
    localparam logic [3:0] c_BUS_BYTES = 4'(DATA_W / 8);

    load_res_t          w_res;
    logic [c_PKT_W-1:0] w_in_pkt;
    logic [c_PKT_W-1:0] w_out_pkt;

    // Lane extraction runs ahead of the output register at the 64-bit width;
    // the narrow bus simply sees zero upper data and a 4-byte size limit.
    always_comb begin
        w_res    = load_extract(64'(in_hrdata), 3'(in_addr), in_hsize,
                                in_signed, c_BUS_BYTES);
        w_in_pkt = {w_res.err, DATA_W'(w_res.value)};
    end

    load_skid_buf #(
        .W (c_PKT_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_pkt)
    );

    assign out_err  = w_out_pkt[DATA_W];
    assign out_data = w_out_pkt[DATA_W-1:0];

endmodule
`default_nettype wire
